dice_roll_prng: RTL and testbench

Parametrised pseudo-random dice generator for the craps datapath. A maximal-length Fibonacci LFSR of configurable width runs continuously. On request, a roll controller draws NUM_DICE unbiased values in 1..6 by rejection sampling and presents them, plus their sum, with a one-cycle valid strobe. It sits between the game-control FSM (which issues roll requests) and the dice display/scoring logic.

---
 rtl/dice_roll_prng.sv | 156 +++++++++++++++
 tb/tb_dice_roll_prng.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_prng.sv
// Dice PRNG: free-running Fibonacci LFSR feeding a rejection-sampling roll controller.
// Define DICE_SUM_EN to build the sum register and adder; otherwise sum is tied to zero.

module dice_roll_prng #(
    parameter int unsigned        WIDTH      = 16,
    parameter logic [WIDTH-1:0]   TAPS       = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0]   RESET_SEED = WIDTH'(16'hACE1),
    parameter int unsigned        NUM_DICE   = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        seed,
    input  logic                    load,
    input  logic                    req,
    output logic                    busy,
    output logic                    valid,
    output logic [3*NUM_DICE-1:0]   dice,
    output logic [5:0]              sum
);

    localparam int unsigned        DICE_W    = 3 * NUM_DICE;
    localparam int unsigned        IDX_W     = (NUM_DICE > 1) ? $clog2(NUM_DICE) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_DICE - 1);
    localparam logic [1:0]         LAST_STEP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } fsm_t;

    fsm_t               fsm_q,   fsm_d;
    logic [WIDTH-1:0]   lfsr_q,  lfsr_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [1:0]         step_q,  step_d;
    logic [DICE_W-1:0]  slots_q, slots_d;
    logic               busy_q,  busy_d;
    logic               valid_q, valid_d;
    logic [DICE_W-1:0]  dice_q,  dice_d;

    logic [2:0]         sample_c;
    logic               accept_c;
    logic [DICE_W-1:0]  slots_ins_c;

    // Next-state logic; load overrides the roll controller and the LFSR step
    always_comb begin
        fsm_d       = fsm_q;
        lfsr_d      = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
        idx_d       = idx_q;
        step_d      = step_q;
        slots_d     = slots_q;
        busy_d      = busy_q;
        valid_d     = 1'b0;
        dice_d      = dice_q;

        sample_c    = lfsr_q[2:0];
        accept_c    = (sample_c != 3'd0) && (sample_c != 3'd7);
        slots_ins_c = slots_q;
        slots_ins_c[3*int'(idx_q) +: 3] = sample_c;

        case (fsm_q)
            IDLE: begin
                if (req) begin
                    fsm_d  = DRAW;
                    idx_d  = '0;
                    step_d = '0;
                    busy_d = 1'b1;
                end
            end
            DRAW: begin
                step_d = (step_q == LAST_STEP) ? 2'd0 : 2'(step_q + 2'd1);
                if ((step_q == LAST_STEP) && accept_c) begin
                    slots_d = slots_ins_c;
                    if (idx_q == LAST_IDX) begin
                        // Publish on entry to DONE so dice/valid are visible during DONE
                        fsm_d   = DONE;
                        valid_d = 1'b1;
                        dice_d  = slots_ins_c;
                    end else begin
                        idx_d = IDX_W'(idx_q + IDX_W'(1));
                    end
                end
            end
            DONE: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
            default: begin
                fsm_d  = IDLE;
                busy_d = 1'b0;
            end
        endcase

        if (load) begin
            lfsr_d  = (seed == '0) ? WIDTH'(1) : seed;
            fsm_d   = IDLE;
            idx_d   = '0;
            step_d  = '0;
            slots_d = slots_q;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            dice_d  = dice_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            lfsr_q  <= RESET_SEED;
            idx_q   <= '0;
            step_q  <= '0;
            slots_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            dice_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            lfsr_q  <= lfsr_d;
            idx_q   <= idx_d;
            step_q  <= step_d;
            slots_q <= slots_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            dice_q  <= dice_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign dice  = dice_q;

`ifdef DICE_SUM_EN
    logic [5:0] sum_q, sum_d;

    // Sum tracks whatever dice will hold next, so it updates and holds with them
    always_comb begin
        sum_d = 6'd0;
        for (int unsigned k = 0; k < NUM_DICE; k++) begin
            sum_d = 6'(sum_d + 6'(dice_d[3*k +: 3]));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= 6'd0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;
`else
    assign sum = 6'd0;
`endif

endmodule

// File: tb/tb_dice_roll_prng.sv
// Bench for dice_roll_prng: per-cycle compare against a roll-planning model,
// directed seeds with hand-derived dice, abort/priority cases and face statistics.

module tb_dice_roll_prng;

    localparam int ND = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] seed  = 16'h0;
    logic        load  = 1'b0;
    logic        req   = 1'b0;
    logic        busy;
    logic        valid;
    logic [5:0]  dice;
    logic [5:0]  sum;

    dice_roll_prng #(
        .WIDTH      (16),
        .TAPS       (16'hB400),
        .RESET_SEED (16'hACE1),
        .NUM_DICE   (ND)
    ) dut (
        .clock (clock),
        .reset (reset),
        .seed  (seed),
        .load  (load),
        .req   (req),
        .busy  (busy),
        .valid (valid),
        .dice  (dice),
        .sum   (sum)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], ^(x & 16'hB400)};
    endfunction

    // Model: LFSR value per cycle, plus a pre-planned roll (valid cycle and dice)
    logic [15:0] m_state = 16'hACE1;
    bit          act     = 1'b0;
    int          vcyc    = 0;
    int          n_edge  = 0;
    logic [5:0]  r_dice  = '0;
    logic [5:0]  r_sum   = '0;
    logic [5:0]  m_dice  = '0;
    logic [5:0]  m_sum   = '0;
    bit          e_busy  = 1'b0;
    bit          e_valid = 1'b0;
    logic [5:0]  e_dice  = '0;
    logic [5:0]  e_sum   = '0;

    task automatic model_init();
        m_state = 16'hACE1;
        act = 1'b0; vcyc = 0; n_edge = 0;
        m_dice = '0; m_sum = '0;
        e_busy = 1'b0; e_valid = 1'b0; e_dice = '0; e_sum = '0;
    endtask

    // Accepted at edge t; s1 is the LFSR value during cycle t+1; samples fall on t+3, t+6, ...
    task automatic plan_roll(input int t, input logic [15:0] s1);
        logic [15:0] x;
        logic [2:0]  v;
        int          got;
        int          cyc;
        x = lfsr_step(lfsr_step(s1));
        cyc = t + 3;
        got = 0;
        r_dice = '0;
        r_sum = '0;
        for (int g = 0; g < 2000 && got < ND; g++) begin
            v = x[2:0];
            if (v != 3'd0 && v != 3'd7) begin
                r_dice[3*got +: 3] = v;
                r_sum = r_sum + 6'(v);
                got++;
            end
            if (got < ND) begin
                x = lfsr_step(lfsr_step(lfsr_step(x)));
                cyc += 3;
            end
        end
        vcyc = cyc + 1;
        act = 1'b1;
    endtask

    task automatic model_edge();
        bit busy_prev;
        n_edge++;
        busy_prev = act;
        if (act && vcyc == n_edge) begin
            m_dice = r_dice;
            m_sum  = r_sum;
            act    = 1'b0;
        end
        if (load) begin
            m_state = (seed == 16'h0) ? 16'h0001 : seed;
            act = 1'b0;
        end else begin
            m_state = lfsr_step(m_state);
        end
        if (!load && req && !busy_prev) plan_roll(n_edge, m_state);
        e_busy  = act;
        e_valid = act && (vcyc == n_edge + 1);
        e_dice  = e_valid ? r_dice : m_dice;
        e_sum   = e_valid ? r_sum  : m_sum;
    endtask

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_init();
            else model_edge();
        end
    end

    // Per-cycle compare, mid-cycle
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("busy",  32'(busy),  32'(e_busy));
                chk("valid", 32'(valid), 32'(e_valid));
                chk("dice",  32'(dice),  32'(e_dice));
`ifdef DICE_SUM_EN
                chk("sum",   32'(sum),   32'(e_sum));
`else
                chk("sum",   32'(sum),   32'd0);
`endif
                chk("lfsr",  32'(dut.lfsr_q), 32'(m_state));
            end
        end
    end

    // Called at a negedge: load for one cycle, then check the state that results
    task automatic load_seed(input logic [15:0] s, input logic [15:0] want_state);
        load = 1'b1;
        seed = s;
        @(negedge clock);
        load = 1'b0;
        chk("seed_state", 32'(dut.lfsr_q), 32'(want_state));
    endtask

    // Called at a negedge; returns at the negedge of the valid cycle, lat = cycles after accept
    task automatic do_roll(output int lat);
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        lat = 0;
        for (int k = 1; k <= 400; k++) begin
            if (valid) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end
    endtask

    function automatic logic [5:0] exp_sum(input logic [5:0] s);
`ifdef DICE_SUM_EN
        return s;
`else
        return 6'd0 & s;
`endif
    endfunction

    int lat;
    int vcount;
    int face_cnt [2][7];
    logic [2:0] d0, d1;

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_dice",  32'(dice),  32'd0);
        chk("rst_sum",   32'(sum),   32'd0);
        chk("rst_lfsr",  32'(dut.lfsr_q), 32'h0000ACE1);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Seed 0x0100: samples 1 then 3 with no rejection
        load_seed(16'h0100, 16'h0100);
        do_roll(lat);
        chk("min_lat",  32'(lat),  32'd7);
        chk("min_dice", 32'(dice), 32'h19);
        chk("min_sum",  32'(sum),  32'(exp_sum(6'd4)));
        @(negedge clock);
        chk("min_busy_after", 32'(busy), 32'd0);

        // Seed 0x1190: first sample 7 rejected, then 2 and 2
        load_seed(16'h1190, 16'h1190);
        do_roll(lat);
        chk("rej_lat",  32'(lat),  32'd10);
        chk("rej_dice", 32'(dice), 32'h12);
        chk("rej_sum",  32'(sum),  32'(exp_sum(6'd4)));
        @(negedge clock);

        // Zero seed is replaced by 1; roll draws 2 then 6 after three rejections
        load_seed(16'h0000, 16'h0001);
        do_roll(lat);
        chk("zero_lat",  32'(lat),  32'd16);
        chk("zero_dice", 32'(dice), 32'h32);
        chk("zero_sum",  32'(sum),  32'(exp_sum(6'd8)));
        @(negedge clock);

        // Load during DRAW aborts the roll
        load_seed(16'h0100, 16'h0100);
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        load = 1'b1;
        seed = 16'h1190;
        @(negedge clock);
        load = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        vcount = 0;
        repeat (20) begin
            @(negedge clock);
            if (valid) vcount++;
        end
        chk("abort_nvalid", 32'(vcount), 32'd0);
        chk("abort_dice",   32'(dice),   32'h32);

        // req and load together: req dropped
        req = 1'b1;
        load = 1'b1;
        seed = 16'h0100;
        @(negedge clock);
        req = 1'b0;
        load = 1'b0;
        chk("reqload_busy", 32'(busy), 32'd0);
        vcount = 0;
        repeat (12) begin
            @(negedge clock);
            if (valid) vcount++;
        end
        chk("reqload_nvalid", 32'(vcount), 32'd0);

        // Extra req pulses while busy are ignored
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        repeat (2) @(negedge clock);
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        vcount = 0;
        repeat (60) begin
            if (valid) vcount++;
            @(negedge clock);
        end
        chk("busyreq_nvalid", 32'(vcount), 32'd1);

        // Reset asserted mid-roll, mid-cycle
        req = 1'b1;
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_dice",  32'(dice),  32'd0);
        chk("mid_rst_sum",   32'(sum),   32'd0);
        chk("mid_rst_lfsr",  32'(dut.lfsr_q), 32'h0000ACE1);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Statistics over back-to-back rolls
        for (int i = 0; i < 2; i++)
            for (int f = 0; f < 7; f++) face_cnt[i][f] = 0;
        for (int r = 0; r < 6000; r++) begin
            do_roll(lat);
            chk("roll_done", 32'(lat != 0), 32'd1);
            d0 = dice[2:0];
            d1 = dice[5:3];
            face_cnt[0][d0]++;
            face_cnt[1][d1]++;
`ifdef DICE_SUM_EN
            chk("roll_sum", 32'(sum), 32'(d0) + 32'(d1));
`else
            chk("roll_sum", 32'(sum), 32'd0);
`endif
            @(negedge clock);
        end
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("face_zero_d%0d", i), 32'(face_cnt[i][0]), 32'd0);
            for (int f = 1; f <= 6; f++) begin
                n_checks++;
                if (face_cnt[i][f] >= 900 && face_cnt[i][f] <= 1100) n_pass++;
                else $display("FAIL face_d%0d_f%0d got=%0d want=900..1100", i, f, face_cnt[i][f]);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
